decode_stage_p: RTL and testbench

- Parametrised instruction-decode pipeline stage: decodes a 32-bit instruction, reads two operands from an internal register file, and registers the decoded fields into a valid/ready output slot feeding the execute stage.
- Adds over the previous-generation decode stage:
  - configurable data width and register count;
  - hardwired-zero register;
  - write-back bypass;
  - load-use hazard bubble;
  - flush;
  - backpressure handshake.

---
 rtl/decode_pkg.sv | 35 +++
 rtl/decode_stage_p_if.sv | 31 +++
 rtl/decode_stage_p_regfile_bp.sv | 46 ++++
 rtl/decode_stage_p.sv | 105 ++++++++++
 tb/tb_decode_stage_p.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared instruction field positions and decoded-field type
// Contents: bit-position constants for the instruction word, the decoded
// slot type (non-operand fields) and a helper that extracts them.
package decode_pkg;

  localparam int RS1_LSB     = 16;
  localparam int RS2_LSB     = 11;
  localparam int RD_LSB      = 21;
  localparam int AOP_MSB     = 28;
  localparam int AOP_LSB     = 26;
  localparam int DATASRC_BIT = 29;
  localparam int LOAD_BIT    = 30;
  localparam int REGF_W      = 5;   // encoded width of a register field
  localparam int IMM_W       = 16;

  // Destination kept at full encoded width; the stage trims it to REG_AW.
  typedef struct packed {
    logic [REGF_W-1:0] rd;
    logic [IMM_W-1:0]  imm;
    logic              datasrc;
    logic [2:0]        aop;
    logic              is_load;
  } dec_fields_t;

  function automatic dec_fields_t decode_inst(input logic [30:0] inst);
    dec_fields_t f;
    f.rd      = inst[RD_LSB +: REGF_W];
    f.imm     = inst[IMM_W-1:0];
    f.datasrc = inst[DATASRC_BIT];
    f.aop     = inst[AOP_MSB:AOP_LSB];
    f.is_load = inst[LOAD_BIT];
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// rtl/decode_stage_p_if.sv - fetch-side and execute-side handshake bundle
// Signals: in_valid/in_ready/inst (fetch -> decode), out_valid/out_ready plus
// decoded slot fields rdata1/rdata2/wtsel/imm/datasrc/aop/is_load (decode -> execute).
// slave = decode stage, master = surrounding pipeline / bench.
interface decode_stage_p_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [REG_AW-1:0] wtsel;
  logic [15:0]       imm;
  logic              datasrc;
  logic [2:0]        aop;
  logic              is_load;

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, rdata1, rdata2, wtsel, imm, datasrc, aop, is_load
  );

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, rdata1, rdata2, wtsel, imm, datasrc, aop, is_load
  );
endinterface

// File: rtl/decode_stage_p_regfile_bp.sv
// rtl/decode_stage_p_regfile_bp.sv - 2-read/1-write register file with write-first bypass
// Ports: clk, rst (async active-low), wb_en/wb_sel/wb_data write port,
// rs1/rs2 read addresses, rdata1/rdata2 combinational read data.
module regfile_bp #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;
  logic              rs1_zero;
  logic              rs2_zero;

  // Writes to the hardwired-zero register are dropped, so it never needs
  // special handling on the storage side beyond this gate.
  assign wr_ok    = wb_en & ~((ZERO_REG != 0) && (wb_sel == '0));
  assign rs1_zero = (ZERO_REG != 0) && (rs1 == '0);
  assign rs2_zero = (ZERO_REG != 0) && (rs2 == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_sel] <= wb_data;
    end
  end

  // Write-first: a same-cycle write-back wins over the stored value.
  assign rdata1 = rs1_zero                    ? '0      :
                  (wb_en && wb_sel == rs1)    ? wb_data : regs[rs1];
  assign rdata2 = rs2_zero                    ? '0      :
                  (wb_en && wb_sel == rs2)    ? wb_data : regs[rs2];

endmodule

// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - instruction decode stage with register read and output slot
// Ports: clk, rst (async active-low); bus (slave) carries the fetch handshake,
// instruction and the registered decoded slot; wb_en/wb_sel/wb_data write back
// into the register file; flush drops both the held and the incoming instruction.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  decode_stage_p_if.slave          bus,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_sel,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush
);

  localparam int REG_AW = $clog2(NREG);

  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [DATA_W-1:0] rd1_bp;
  logic [DATA_W-1:0] rd2_bp;
  dec_fields_t       dec;
  dec_fields_t       slot_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;
  logic              valid_q;
  logic [REG_AW-1:0] slot_rd;
  logic              hazard;
  logic              in_ready;
  logic              accept;
  logic              inst_unused;

  assign inst_unused = bus.inst[31];

  assign rs1 = bus.inst[RS1_LSB +: REG_AW];
  assign rs2 = bus.inst[RS2_LSB +: REG_AW];
  assign dec = decode_inst(bus.inst[30:0]);

  regfile_bp #(
    .DATA_W  (DATA_W),
    .NREG    (NREG),
    .REG_AW  (REG_AW),
    .ZERO_REG(ZERO_REG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wb_en  (wb_en),
    .wb_sel (wb_sel),
    .wb_data(wb_data),
    .rs1    (rs1),
    .rs2    (rs2),
    .rdata1 (rd1_bp),
    .rdata2 (rd2_bp)
  );

  assign slot_rd = slot_q.rd[REG_AW-1:0];

  // A load in the slot cannot forward its result yet; stall a dependent
  // instruction until the slot drains. Loads into r0 produce nothing.
  assign hazard = valid_q & slot_q.is_load & bus.in_valid
                & ((slot_rd == rs1) | (slot_rd == rs2))
                & ~((ZERO_REG != 0) && (slot_rd == '0));

  assign in_ready = (~valid_q | bus.out_ready) & ~hazard;
  assign accept   = bus.in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      slot_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      // Field registers only move on accept; a stalled or drained slot holds.
      if (accept) begin
        slot_q   <= dec;
        rdata1_q <= rd1_bp;
        rdata2_q <= rd2_bp;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rdata2    = rdata2_q;
  assign bus.wtsel     = slot_rd;
  assign bus.imm       = slot_q.imm;
  assign bus.datasrc   = slot_q.datasrc;
  assign bus.aop       = slot_q.aop;
  assign bus.is_load   = slot_q.is_load;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - directed vector bench for decode_stage_p
module tb_decode_stage_p;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        flush;

  decode_stage_p_if #(.DATA_W(32), .REG_AW(5)) bus ();

  decode_stage_p #(.DATA_W(32), .NREG(32), .ZERO_REG(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .wb_en  (wb_en),
    .wb_sel (wb_sel),
    .wb_data(wb_data),
    .flush  (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        in_valid;
    logic [31:0] inst;
    logic        out_ready;
    logic        flush;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [4:0]  e_wt;
    logic [15:0] e_imm;
    logic [2:0]  e_aop;
    logic        e_ds;
    logic        e_ld;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [31:0] mk(input logic ld, input logic ds, input logic [2:0] aop,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [15:0] imm);
    return {1'b0, ld, ds, aop, rd, rs1, imm};
  endfunction

  function automatic vec_t v(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                             input logic iv, input logic [31:0] ins, input logic ordy,
                             input logic fl, input logic eir, input logic eov,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wt,
                             input logic [15:0] im, input logic [2:0] ao, input logic ds,
                             input logic ld);
    vec_t t;
    t.wb_en = we; t.wb_sel = ws; t.wb_data = wd; t.in_valid = iv; t.inst = ins;
    t.out_ready = ordy; t.flush = fl; t.e_in_ready = eir; t.e_out_valid = eov;
    t.e_r1 = r1; t.e_r2 = r2; t.e_wt = wt; t.e_imm = im; t.e_aop = ao; t.e_ds = ds; t.e_ld = ld;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic chk_outs(input int idx, input logic ov, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wt, input logic [15:0] im, input logic [2:0] ao,
                          input logic ds, input logic ld);
    chk("out_valid", idx, {31'd0, bus.out_valid}, {31'd0, ov});
    chk("rdata1",    idx, bus.rdata1, r1);
    chk("rdata2",    idx, bus.rdata2, r2);
    chk("wtsel",     idx, {27'd0, bus.wtsel}, {27'd0, wt});
    chk("imm",       idx, {16'd0, bus.imm}, {16'd0, im});
    chk("aop",       idx, {29'd0, bus.aop}, {29'd0, ao});
    chk("datasrc",   idx, {31'd0, bus.datasrc}, {31'd0, ds});
    chk("is_load",   idx, {31'd0, bus.is_load}, {31'd0, ld});
  endtask

  vec_t vecs [$];

  initial begin
    logic [31:0] i_a, i_b, i_c, i_d, i_l, i_e, i_l0, i_f, i_g, i_h, i_z;

    i_a  = mk(1'b0, 1'b1, 3'd5, 5'd5,  5'd3,  16'hBEEF);  // rs2 = 23 (reads 0)
    i_b  = mk(1'b0, 1'b0, 3'd2, 5'd6,  5'd7,  16'h1800);  // rs2 = 3
    i_c  = mk(1'b0, 1'b0, 3'd1, 5'd1,  5'd0,  16'h0000);  // rs1 = rs2 = 0
    i_d  = mk(1'b0, 1'b1, 3'd7, 5'd9,  5'd3,  16'h3800);  // rs2 = 7
    i_l  = mk(1'b1, 1'b0, 3'd0, 5'd4,  5'd3,  16'h0004);  // load rd=4, rs2 = 0
    i_e  = mk(1'b0, 1'b0, 3'd3, 5'd8,  5'd7,  16'h2000);  // rs2 = 4 -> depends on load
    i_l0 = mk(1'b1, 1'b0, 3'd0, 5'd0,  5'd3,  16'h0000);  // load rd=0
    i_f  = mk(1'b0, 1'b0, 3'd4, 5'd2,  5'd0,  16'h0005);  // rs1 = rs2 = 0
    i_g  = mk(1'b0, 1'b1, 3'd6, 5'd10, 5'd3,  16'h7777);  // flushed away
    i_h  = mk(1'b0, 1'b0, 3'd1, 5'd11, 5'd12, 16'h6000);  // rs2 = 12
    i_z  = mk(1'b0, 1'b0, 3'd0, 5'd13, 5'd3,  16'h6000);  // rs1 = 3, rs2 = 12 after reset

    //         we   sel    wdata         iv  inst  ordy fl  eir eov  r1            r2            wt     imm       aop   ds  ld
    vecs.push_back(v(1, 5'd3,  32'h1234,     0, 0,    1,  0,  1,  0,   32'h0,        32'h0,        5'd0,  16'h0,    3'd0, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_a,  1,  0,  1,  1,   32'h1234,     32'h0,        5'd5,  16'hBEEF, 3'd5, 1,  0));
    vecs.push_back(v(1, 5'd7,  32'hA5A5A5A5, 1, i_b,  1,  0,  1,  1,   32'hA5A5A5A5, 32'h1234,     5'd6,  16'h1800, 3'd2, 0,  0));
    vecs.push_back(v(1, 5'd0,  32'hFFFF,     0, 0,    1,  0,  1,  0,   32'hA5A5A5A5, 32'h1234,     5'd6,  16'h1800, 3'd2, 0,  0));
    vecs.push_back(v(1, 5'd0,  32'hFFFF,     1, i_c,  1,  0,  1,  1,   32'h0,        32'h0,        5'd1,  16'h0,    3'd1, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_d,  0,  0,  0,  1,   32'h0,        32'h0,        5'd1,  16'h0,    3'd1, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_d,  0,  0,  0,  1,   32'h0,        32'h0,        5'd1,  16'h0,    3'd1, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_d,  0,  0,  0,  1,   32'h0,        32'h0,        5'd1,  16'h0,    3'd1, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_d,  1,  0,  1,  1,   32'h1234,     32'hA5A5A5A5, 5'd9,  16'h3800, 3'd7, 1,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_l,  1,  0,  1,  1,   32'h1234,     32'h0,        5'd4,  16'h0004, 3'd0, 0,  1));
    vecs.push_back(v(1, 5'd4,  32'h4444,     1, i_e,  1,  0,  0,  0,   32'h1234,     32'h0,        5'd4,  16'h0004, 3'd0, 0,  1));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_e,  1,  0,  1,  1,   32'hA5A5A5A5, 32'h4444,     5'd8,  16'h2000, 3'd3, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_l0, 1,  0,  1,  1,   32'h1234,     32'h0,        5'd0,  16'h0,    3'd0, 0,  1));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_f,  1,  0,  1,  1,   32'h0,        32'h0,        5'd2,  16'h0005, 3'd4, 0,  0));
    vecs.push_back(v(1, 5'd12, 32'hC0FFEE00, 1, i_g,  1,  1,  1,  0,   32'h0,        32'h0,        5'd2,  16'h0005, 3'd4, 0,  0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, i_h,  1,  0,  1,  1,   32'hC0FFEE00, 32'hC0FFEE00, 5'd11, 16'h6000, 3'd1, 0,  0));

    rst = 1'b0; wb_en = 1'b0; wb_sel = '0; wb_data = '0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.inst = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", -1, {31'd0, bus.in_ready}, 32'd1);
    chk_outs(-1, 1'b0, 32'h0, 32'h0, 5'd0, 16'h0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      wb_en = vecs[k].wb_en; wb_sel = vecs[k].wb_sel; wb_data = vecs[k].wb_data;
      bus.in_valid = vecs[k].in_valid; bus.inst = vecs[k].inst;
      bus.out_ready = vecs[k].out_ready; flush = vecs[k].flush;
      @(negedge clk);
      chk("in_ready", k, {31'd0, bus.in_ready}, {31'd0, vecs[k].e_in_ready});
      @(posedge clk);
      #1;
      chk_outs(k, vecs[k].e_out_valid, vecs[k].e_r1, vecs[k].e_r2, vecs[k].e_wt,
               vecs[k].e_imm, vecs[k].e_aop, vecs[k].e_ds, vecs[k].e_ld);
    end

    // Asynchronous reset while the slot holds a valid instruction.
    wb_en = 1'b0; bus.in_valid = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_outs(100, 1'b0, 32'h0, 32'h0, 5'd0, 16'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.inst = i_z;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_outs(101, 1'b1, 32'h0, 32'h0, 5'd13, 16'h6000, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
